// File: rtl/anomaly_detect_pkg.sv
// Shared types and node-word layout helpers for the multi-channel isolation-tree anomaly detector.
package anomaly_detect_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      DONE
   } eng_state_t;

   // Node word, MSB first: {is_leaf, threshold[DATA_W], left[AW], right[AW]}
   function automatic int node_w(input int data_w, input int aw);
      return 1 + data_w + 2 * aw;
   endfunction

   function automatic int right_off();
      return 0;
   endfunction

   function automatic int left_off(input int aw);
      return aw;
   endfunction

   function automatic int thr_off(input int aw);
      return 2 * aw;
   endfunction

   function automatic int leaf_off(input int data_w, input int aw);
      return 2 * aw + data_w;
   endfunction

endpackage

// File: rtl/ad_sync_fifo.sv
// Single-clock FIFO with extra-bit wrap pointers; push ignored when full, pop ignored when empty.
module ad_sync_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: storage arrays are not reset; only the pointers define which entries are valid.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/anomaly_detect_mc.sv
// Multi-channel isolation-tree anomaly detector: FIFO-buffered samples walk a loadable node store.
// Optional per-channel anomaly counters with output cnt_flat when ANOMALY_DETECT_MC_CNT_EN is defined.
module anomaly_detect_mc
   import anomaly_detect_pkg::*;
#(
   parameter int  DATA_W     = 8,
   parameter int  NUM_CH     = 4,
   parameter int  FIFO_DEPTH = 16,
   parameter int  TREE_NODES = 32,
   parameter int  MAX_DEPTH  = 15,
   localparam int AW         = $clog2(TREE_NODES),
   localparam int CW         = $clog2(NUM_CH),
   localparam int PW         = $clog2(MAX_DEPTH + 1),
   localparam int NODE_W     = node_w(DATA_W, AW)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CW-1:0]     in_ch,
   input  logic              tree_wr_en,
   input  logic [AW-1:0]     tree_wr_addr,
   input  logic [NODE_W-1:0] tree_wr_data,
   input  logic [PW-1:0]     anomaly_thresh,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CW-1:0]     res_ch,
   output logic [PW-1:0]     res_path,
   output logic              res_anomaly,
   output logic              busy
`ifdef ANOMALY_DETECT_MC_CNT_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] cnt_flat
`endif
);

   localparam int FW     = CW + DATA_W;
   localparam int LEAF_B = leaf_off(DATA_W, AW);
   localparam int THR_B  = thr_off(AW);
   localparam int LEFT_B = left_off(AW);
   localparam int RGHT_B = right_off();

   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [FW-1:0]     fifo_rd;

   eng_state_t        state;
   logic [AW-1:0]     node_ptr;
   logic [PW-1:0]     path;
   logic [PW-1:0]     thr_q;
   logic [DATA_W-1:0] data_q;
   logic [CW-1:0]     ch_q;

   logic [NODE_W-1:0] tree_mem [TREE_NODES];
   logic [NODE_W-1:0] node;
   logic              node_leaf;
   logic [DATA_W-1:0] node_thr;
   logic [AW-1:0]     node_l;
   logic [AW-1:0]     node_r;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == IDLE) && !fifo_empty;
   assign busy     = !fifo_empty || (state != IDLE);

   assign node      = tree_mem[node_ptr];
   assign node_leaf = node[LEAF_B];
   assign node_thr  = node[THR_B +: DATA_W];
   assign node_l    = node[LEFT_B +: AW];
   assign node_r    = node[RGHT_B +: AW];

   ad_sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data ({in_ch, in_data}),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // The node store survives reset; loads are only honoured while nothing is queued or walking.
   always_ff @(posedge clk) begin
      if (tree_wr_en && !busy)
         tree_mem[tree_wr_addr] <= tree_wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         node_ptr    <= '0;
         path        <= '0;
         thr_q       <= '0;
         data_q      <= '0;
         ch_q        <= '0;
         res_valid   <= 1'b0;
         res_ch      <= '0;
         res_path    <= '0;
         res_anomaly <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  {ch_q, data_q} <= fifo_rd;
                  node_ptr       <= '0;
                  path           <= '0;
                  thr_q          <= anomaly_thresh;
                  state          <= WALK;
               end
            end
            WALK: begin
               // A non-leaf at the depth cap ends the walk with the capped length.
               if (node_leaf || (path == PW'(MAX_DEPTH))) begin
                  state       <= DONE;
                  res_valid   <= 1'b1;
                  res_ch      <= ch_q;
                  res_path    <= path;
                  res_anomaly <= (path < thr_q);
               end else begin
                  node_ptr <= (data_q < node_thr) ? node_l : node_r;
                  path     <= path + 1'b1;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ANOMALY_DETECT_MC_CNT_EN
   logic [CNT_W-1:0] cnt [NUM_CH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++)
            cnt[i] <= '0;
      end else if (res_valid && res_ready && res_anomaly) begin
         for (int i = 0; i < NUM_CH; i++)
            if ((res_ch == CW'(i)) && (cnt[i] != '1))
               cnt[i] <= cnt[i] + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign cnt_flat[g*CNT_W +: CNT_W] = cnt[g];
   end
`endif

endmodule
